// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared opcode constants and sequencer state type
package fib_pkg;

   localparam logic [1:0] OP_ADC = 2'd0;
   localparam logic [1:0] OP_SBB = 2'd1;
   localparam logic [1:0] OP_AND = 2'd2;
   localparam logic [1:0] OP_OR  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fib_sequencer.sv
// rtl/fib_sequencer.sv - multi-byte Fibonacci sequencer driving an external byte ALU
module fib_sequencer
   import fib_pkg::*;
#(
   parameter int NBYTES = 4,
   parameter int N_W    = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [N_W-1:0]      n,
   output logic                busy,
   output logic [7:0]          alu_left,
   output logic [7:0]          alu_right,
   output logic                alu_status,
   output logic [1:0]          alu_opcode,
   input  logic [7:0]          alu_result,
   input  logic                alu_status_out,
   output logic [8*NBYTES-1:0] fib,
   output logic [N_W-1:0]      fib_index,
   output logic                overflow,
   output logic                result_valid,
   input  logic                result_ready
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_t          state;
   logic [W-1:0]    a, b, t, next_t;
   logic [IW-1:0]   i;
   logic            c;
   logic [N_W-1:0]  cnt, k;
   logic            last_byte;

   assign last_byte = (i == IW'(NBYTES - 1));
   assign busy      = (state != IDLE);

   // Partial sum with the byte coming back from the ALU merged in place.
   always_comb begin
      next_t = t;
      next_t[8*i +: 8] = alu_result;
   end

   always_comb begin
      alu_left   = 8'd0;
      alu_right  = 8'd0;
      alu_status = 1'b0;
      alu_opcode = 2'd0;
      if (state == ADD) begin
         alu_left   = a[8*i +: 8];
         alu_right  = b[8*i +: 8];
         alu_status = (i == '0) ? 1'b0 : c;
         alu_opcode = OP_ADC;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         a            <= '0;
         b            <= '0;
         t            <= '0;
         i            <= '0;
         c            <= 1'b0;
         cnt          <= '0;
         k            <= '0;
         fib          <= '0;
         fib_index    <= '0;
         overflow     <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a        <= '0;
                  b        <= W'(1);
                  cnt      <= n;
                  k        <= '0;
                  i        <= '0;
                  c        <= 1'b0;
                  overflow <= 1'b0;
                  state    <= (n == '0) ? DONE : ADD;
               end
            end
            ADD: begin
               t <= next_t;
               c <= alu_status_out;
               if (last_byte) begin
                  a   <= b;
                  b   <= next_t;
                  k   <= k + 1'b1;
                  cnt <= cnt - 1'b1;
                  i   <= '0;
                  // The final carry only affects a b that is never reported.
                  if (cnt == N_W'(1)) begin
                     state <= DONE;
                  end else if (alu_status_out) begin
                     overflow <= 1'b1;
                     state    <= DONE;
                  end
               end else begin
                  i <= i + 1'b1;
               end
            end
            DONE: begin
               if (!result_valid) begin
                  fib          <= a;
                  fib_index    <= k;
                  result_valid <= 1'b1;
               end else if (result_ready) begin
                  result_valid <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fib_sequencer.sv
// tb/tb_fib_sequencer.sv - randomized self-checking bench for fib_sequencer
module tb_fib_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        start4 = 1'b0, rr4 = 1'b0, busy4, rv4, ov4, as4, so4;
   logic [7:0]  n4 = 8'd0, idx4, al4, ar4, res4;
   logic [1:0]  op4;
   logic [31:0] fib4;

   logic        start1 = 1'b0, rr1 = 1'b0, busy1, rv1, ov1, as1, so1;
   logic [7:0]  n1 = 8'd0, idx1, al1, ar1, res1, fib1;
   logic [1:0]  op1;

   int cmp_cnt = 0;
   int err_cnt = 0;
   bit op_nonzero = 1'b0;
   bit status_seen = 1'b0;

   function automatic logic [8:0] alu_f(input logic [7:0] l, input logic [7:0] r,
                                        input logic ci, input logic [1:0] op);
      case (op)
         2'd0:    alu_f = {1'b0, l} + {1'b0, r} + {8'd0, ci};
         2'd1:    alu_f = {1'b0, l} - {1'b0, r} - {8'd0, ci};
         2'd2:    alu_f = {1'b0, l & r};
         default: alu_f = {1'b0, l | r};
      endcase
   endfunction

   assign {so4, res4} = alu_f(al4, ar4, as4, op4);
   assign {so1, res1} = alu_f(al1, ar1, as1, op1);

   fib_sequencer #(.NBYTES(4), .N_W(8)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .n(n4), .busy(busy4),
      .alu_left(al4), .alu_right(ar4), .alu_status(as4), .alu_opcode(op4),
      .alu_result(res4), .alu_status_out(so4), .fib(fib4), .fib_index(idx4),
      .overflow(ov4), .result_valid(rv4), .result_ready(rr4));

   fib_sequencer #(.NBYTES(1), .N_W(8)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .n(n1), .busy(busy1),
      .alu_left(al1), .alu_right(ar1), .alu_status(as1), .alu_opcode(op1),
      .alu_result(res1), .alu_status_out(so1), .fib(fib1), .fib_index(idx1),
      .overflow(ov1), .result_valid(rv1), .result_ready(rr1));

   always @(negedge clk) begin
      if (op4 != 2'd0 || op1 != 2'd0) op_nonzero = 1'b1;
      if (as4) status_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      cmp_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: true Fibonacci values, stop when the next value needed no longer fits.
   task automatic model(input int nb, input int nval, output longint f,
                        output int idx, output bit ov);
      longint a, b, nbv, lim;
      lim = longint'(1) << (8 * nb);
      a = 0; b = 1; idx = 0; ov = 1'b0;
      for (int it = 1; it <= nval; it++) begin
         nbv = a + b;
         a = b;
         idx = it;
         if (it == nval) break;
         if (nbv >= lim) begin ov = 1'b1; break; end
         b = nbv;
      end
      f = a;
   endtask

   task automatic run(input bit sel, input int nval, input int hold, input string tag);
      longint ef; int eidx; bit eov; int cyc; int nb;
      nb = sel ? 1 : 4;
      model(nb, nval, ef, eidx, eov);
      @(negedge clk);
      if (sel) begin n1 = 8'(nval); start1 = 1'b1; end
      else     begin n4 = 8'(nval); start4 = 1'b1; end
      @(posedge clk); #1;
      start1 = 1'b0; start4 = 1'b0;
      @(negedge clk);
      cyc = 0;
      while (!(sel ? rv1 : rv4) && cyc < 400) begin
         @(posedge clk); cyc++; @(negedge clk);
      end
      check({tag, "_latency"}, 64'(cyc), 64'(eidx * nb + 1));
      check({tag, "_fib"}, sel ? 64'(fib1) : 64'(fib4), 64'(ef));
      check({tag, "_index"}, sel ? 64'(idx1) : 64'(idx4), 64'(eidx));
      check({tag, "_ovf"}, sel ? 64'(ov1) : 64'(ov4), 64'(eov));
      repeat (hold) @(negedge clk);
      if (sel) rr1 = 1'b1; else rr4 = 1'b1;
      @(negedge clk);
      rr1 = 1'b0; rr4 = 1'b0;
      check({tag, "_idle"}, sel ? {63'd0, rv1 | busy1} : {63'd0, rv4 | busy4}, 64'd0);
      check({tag, "_keep"}, sel ? 64'(fib1) : 64'(fib4), 64'(ef));
   endtask

   initial begin
      #12;
      check("rst_outs", {busy4, rv4, ov4, as4, op4, al4, ar4, idx4, fib4},
            64'd0);
      check("rst_outs1", {busy1, rv1, ov1, as1, op1, al1, ar1, idx1, fib1}, 64'd0);
      @(negedge clk); reset = 1'b0;

      status_seen = 1'b0;
      run(1'b0, 0, 0, "n0");
      check("n0_alu_status", 64'(status_seen), 64'd0);
      run(1'b0, 1, 0, "n1");
      run(1'b0, 14, 2, "n14");
      run(1'b0, 47, 0, "n47");
      run(1'b0, 48, 1, "n48");
      run(1'b1, 13, 0, "b1_n13");
      run(1'b1, 20, 0, "b1_n20");

      for (int r = 0; r < 8; r++) begin
         run(1'b0, int'($urandom_range(0, 60)), int'($urandom_range(0, 3)), "rnd4");
         run(1'b1, int'($urandom_range(0, 30)), int'($urandom_range(0, 3)), "rnd1");
      end
      check("opcode_adc_only", 64'(op_nonzero), 64'd0);

      // Ready held low: result must hold and a start pulse must be ignored.
      @(negedge clk); n4 = 8'd10; start4 = 1'b1;
      @(negedge clk); start4 = 1'b0;
      repeat (60) begin
         if (!rv4) @(negedge clk);
      end
      for (int h = 0; h < 10; h++) begin
         if (h == 4) begin n4 = 8'd3; start4 = 1'b1; end
         else start4 = 1'b0;
         @(negedge clk);
      end
      start4 = 1'b0;
      check("hold_valid", 64'(rv4), 64'd1);
      check("hold_fib", 64'(fib4), 64'd55);
      check("hold_index", 64'(idx4), 64'd10);
      rr4 = 1'b1; @(negedge clk); rr4 = 1'b0;
      @(negedge clk);
      check("hold_release", {62'd0, busy4, rv4}, 64'd0);

      // Asynchronous reset in the middle of a run.
      @(negedge clk); n4 = 8'd30; start4 = 1'b1;
      @(negedge clk); start4 = 1'b0;
      repeat (40) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_outs", {busy4, rv4, ov4, as4, op4, al4, ar4, idx4, fib4}, 64'd0);
      @(negedge clk); reset = 1'b0;
      run(1'b0, 5, 0, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
